mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers, serving the multicycle MIPS datapath.
- Supersedes the fixed 32-bit multiply-only path and its startMult/endMult handshake.
- Adds WIDTH parametrisation, signed and unsigned multiply, signed and unsigned divide, MTHI/MTLO-style direct writes, and divide-by-zero reporting.
- The control FSM issues start/op and waits for done; the datapath reads hi/lo into ALUOut.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits; iteration count = WIDTH.

Ports:
Clk  input  1  clock, rising edge
reset  input  1  synchronous active-high reset
start  input  1  request operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
a  input  WIDTH  multiplicand / dividend; sampled with start
b  input  WIDTH  multiplier / divisor; sampled with start
wr_hi  input  1  load hi from wr_data (MTHI)
wr_lo  input  1  load lo from wr_data (MTLO)
wr_data  input  WIDTH  direct write data
busy  output  1  high while the operation is in progress (ITER or FIX)
done  output  1  one-cycle pulse; hi/lo valid in the same cycle
hi  output  WIDTH  product upper half / remainder
lo  output  WIDTH  product lower half / quotient
div_by_zero  output  1  set by a DIV/DIVU with b==0

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; iteration counter=0. Reset asserted mid-operation aborts the operation with the same values; no done pulse.
- States: IDLE, ITER, FIX.
- IDLE, start=1:
  - Latch op.
  - Latch |a| and |b| for signed ops (two's-complement magnitude), raw a and b for unsigned ops.
  - Latch the result sign flags.
  - Clear div_by_zero.
  - Go to ITER with counter=WIDTH.
  - Exception: DIV/DIVU with b==0 goes directly to FIX with the zero-divide flag set.
- ITER: one bit per cycle.
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract with a WIDTH+1-bit partial remainder.
  - Decrement the counter; go to FIX after WIDTH ITER cycles.
- FIX:
  - MULT: negate the 2*WIDTH product if sign(a)^sign(b).
  - DIV: negate the quotient if sign(a)^sign(b); give the remainder the sign of a.
  - Write hi/lo at the end of the FIX cycle, then go to IDLE.
  - Zero-divide: hi/lo are left unchanged and div_by_zero is set instead.
- done is registered and asserts in the first IDLE cycle after FIX, for exactly one cycle.
- Latency: start sampled at cycle T → done at T+WIDTH+2 (T+34 for WIDTH=32). Zero-divide: done at T+2.
- busy=1 in the cycles from T+1 until done, exclusive of the done cycle.
- start while busy: ignored with no effect. start in the done cycle (IDLE): accepted.
- DIV of most-negative by -1 wraps with no flag: lo=most-negative, hi=0.
- Direct writes:
  - wr_hi/wr_lo take effect at the next edge, only in IDLE and only when start=0.
  - Ignored while busy or when start=1 in the same cycle.
  - wr_hi and wr_lo together load both hi and lo.
- div_by_zero is sticky until the next accepted start or reset.
- hi/lo hold their values between operations; they change only in FIX, on direct write, or on reset.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at T → busy T+1..T+33; done at T+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; then start a second MULT in the done cycle → accepted, busy next cycle.
- DIV a=0xFFFFFFF9(-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands → lo=0x7FFFFFFC, hi=0x00000001.
- DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0x00000000, div_by_zero=0.
- wr_hi=1 wr_lo=1 wr_data=0x1234 in IDLE, then DIVU b=0 at T → done at T+2; div_by_zero=1; hi=lo=0x1234. The next start clears div_by_zero.
- start MULT, pulse start+wr_lo at ITER cycle 5, assert reset at ITER cycle 10 → pulses ignored; after reset busy=0, done never pulses, hi=lo=0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle between the multicycle control/datapath and the
// iterative multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit with HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in the FIX cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           Clk,
  input logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t             state_reg, state_next;
  logic               div_reg;
  logic               neg_res_reg;
  logic               neg_rem_reg;
  logic               zdiv_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;
  logic               dz_reg;

  logic               sign_op;
  logic               is_div;
  logic               b_zero;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign sign_op = ~bus.op[0];
  assign is_div  = bus.op[1];
  assign b_zero  = (bus.b == '0);
  assign abs_a   = (sign_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b   = (sign_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Shift-add: upper half accumulates, multiplier bits drain from the bottom.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
  assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                               : {1'b0, acc_reg[2*WIDTH-1:1]};

  // Restoring divide: dividend bits shift out of acc low half, quotient in.
  assign div_shift = {rem_reg[WIDTH-1:0], acc_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};

  assign prod = neg_res_reg ? -acc_reg : acc_reg;
  assign quot = neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem  = neg_rem_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];

  always_ff @(posedge Clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = (is_div && b_zero) ? FIX : ITER;
      ITER:    if (cnt_reg == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      div_reg     <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      zdiv_reg    <= 1'b0;
      cnt_reg     <= '0;
      opnd_reg    <= '0;
      acc_reg     <= '0;
      rem_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
      dz_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIX);
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            div_reg     <= is_div;
            neg_res_reg <= sign_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_reg <= sign_op && bus.a[WIDTH-1];
            zdiv_reg    <= is_div && b_zero;
            dz_reg      <= 1'b0;
            cnt_reg     <= CW'(WIDTH);
            rem_reg     <= '0;
            if (is_div) begin
              opnd_reg <= abs_b;
              acc_reg  <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              opnd_reg <= abs_a;
              acc_reg  <= {{WIDTH{1'b0}}, abs_b};
            end
          end else begin
            if (bus.wr_hi) hi_reg <= bus.wr_data;
            if (bus.wr_lo) lo_reg <= bus.wr_data;
          end
        end
        ITER: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (div_reg) begin
            if (!div_diff[WIDTH]) begin
              rem_reg            <= div_diff;
              acc_reg[WIDTH-1:0] <= {acc_reg[WIDTH-2:0], 1'b1};
            end else begin
              rem_reg            <= div_shift;
              acc_reg[WIDTH-1:0] <= {acc_reg[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_reg <= mul_next;
          end
        end
        FIX: begin
          if (zdiv_reg) begin
            dz_reg <= 1'b1;
          end else if (div_reg) begin
            hi_reg <= rem;
            lo_reg <= quot;
          end else begin
            hi_reg <= prod[2*WIDTH-1:WIDTH];
            lo_reg <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = done_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
  assign bus.div_by_zero = dz_reg;
endmodule
